// File: rtl/link_rx_fifo.sv
// link_rx_fifo: 4-phase link slave feeding a valid/ready FIFO with per-burst checksum
module link_rx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [DATA_W-1:0]        data,
  output logic                     ack,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     burst_done,
  output logic [7:0]               checksum,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, WAIT_REL} state_t;
  state_t state, state_nx;
  logic push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [7:0] sum, d8;
  always_comb begin
    push = (state == IDLE) && req && (fill < (AW+1)'(DEPTH));
    state_nx = push ? WAIT_REL : ((state == WAIT_REL) && req) ? WAIT_REL : IDLE;
  end
  assign ack       = state == WAIT_REL;
  assign out_valid = fill != '0;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign d8        = 8'(data);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      cnt        <= '0;
      sum        <= '0;
      checksum   <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nx;
      burst_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      // the closing word of a burst is folded into checksum, not into sum
      if (push) begin
        if (cnt == CW'(BURST_LEN - 1)) begin
          burst_done <= 1'b1;
          checksum   <= sum + d8;
          cnt        <= '0;
          sum        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          sum <= sum + d8;
        end
      end
    end
  end
endmodule

// File: tb/tb_link_rx_fifo.sv
// tb_link_rx_fifo: directed checks of the link handshake, FIFO ordering and burst checksum
module tb_link_rx_fifo;
  logic clk = 0, rst = 1, req = 0, out_ready = 0;
  logic [7:0] data = 0;
  logic ack, out_valid, burst_done;
  logic [7:0] out_data, checksum;
  logic [2:0] fill;
  int tests = 0, fails = 0, bd_cnt = 0;
  logic [7:0] popq[$];

  link_rx_fifo #(.DATA_W(8), .DEPTH(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .burst_done(burst_done), .checksum(checksum), .fill(fill)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) begin
      popq.delete();
      bd_cnt = 0;
    end else begin
      if (out_valid && out_ready) popq.push_back(out_data);
      if (burst_done) bd_cnt++;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1; req = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    @(negedge clk);
    req = 1; data = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 20);
    if (!ack) chk("ack_rise_timeout", ack, 1);
    req = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack && n < 20);
    if (ack) chk("ack_fall_timeout", ack, 0);
  endtask

  task automatic pp(input logic [7:0] d);
    @(negedge clk);
    req = 1; data = d; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("pp_ack", ack, 1);
    chk("pp_fill", fill, 2);
    req = 0;
    @(negedge clk);
    chk("pp_ack_fall", ack, 0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic seen_ack;
    do_reset();
    chk("rst_ack", ack, 0);
    chk("rst_fill", fill, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_csum", checksum, 0);
    chk("rst_bd", burst_done, 0);

    // reset in the middle of a handshake
    @(negedge clk); req = 1; data = 8'h55;
    @(negedge clk);
    chk("mid_ack_hi", ack, 1);
    #2 rst = 1;
    #1;
    chk("mid_ack", ack, 0);
    chk("mid_fill", fill, 0);
    chk("mid_valid", out_valid, 0);
    @(negedge clk); req = 0; rst = 0;
    send(8'h11);
    chk("mid_next_data", out_data, 8'h11);
    chk("mid_next_fill", fill, 1);

    // single word
    do_reset();
    @(negedge clk); req = 1; data = 8'hA5;
    chk("sw_ack_lo", ack, 0);
    @(negedge clk);
    chk("sw_ack_hi", ack, 1);
    chk("sw_valid", out_valid, 1);
    chk("sw_data", out_data, 8'hA5);
    chk("sw_fill", fill, 1);
    req = 0;
    @(negedge clk);
    chk("sw_ack_fall", ack, 0);
    chk("sw_fill_hold", fill, 1);

    // burst with a draining consumer
    do_reset();
    out_ready = 1;
    send(8'h01); send(8'h02); send(8'h03);
    chk("bu_bd_none", bd_cnt, 0);
    send(8'h04);
    repeat (2) @(negedge clk);
    chk("bu_bd_once", bd_cnt, 1);
    chk("bu_csum", checksum, 8'h0A);
    chk("bu_npop", popq.size(), 4);
    for (int i = 0; i < 4 && i < popq.size(); i++) chk("bu_order", popq[i], i + 1);
    send(8'h07);
    chk("bu_csum_hold", checksum, 8'h0A);
    chk("bu_bd_still", bd_cnt, 1);

    // checksum wraps modulo 256
    do_reset();
    out_ready = 1;
    send(8'hFF); send(8'hFF); send(8'h01); send(8'h03);
    chk("wrap_csum", checksum, 8'h02);
    chk("wrap_bd", bd_cnt, 1);

    // backpressure on a full FIFO
    do_reset();
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("bp_fill4", fill, 4);
    @(negedge clk); req = 1; data = 8'h05;
    seen_ack = 0;
    repeat (3) begin @(negedge clk); seen_ack |= ack; end
    chk("bp_no_ack", seen_ack, 0);
    chk("bp_fill_full", fill, 4);
    chk("bp_head", out_data, 8'h01);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_pop_val", popq.size() > 0 ? popq[0] : 8'hxx, 8'h01);
    chk("bp_fill3", fill, 3);
    chk("bp_ack_wait", ack, 0);
    @(negedge clk);
    chk("bp_ack5", ack, 1);
    chk("bp_fill_re", fill, 4);
    chk("bp_head2", out_data, 8'h02);
    req = 0;
    @(negedge clk);

    // simultaneous push/pop across pointer wrap
    do_reset();
    send(8'h10); send(8'h11);
    chk("pp_fill_start", fill, 2);
    for (int i = 0; i < 8; i++) pp(8'h12 + 8'(i));
    out_ready = 1;
    repeat (4) @(negedge clk);
    out_ready = 0;
    chk("pp_fill_end", fill, 0);
    chk("pp_npop", popq.size(), 10);
    for (int i = 0; i < 10 && i < popq.size(); i++) chk("pp_order", popq[i], 8'h10 + 8'(i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/link_rx_fifo.md
Name: link_rx_fifo

Overview:
- Receive-side stage sitting directly downstream of the link master; replaces the bare slave as the consumer of the 4-phase req/ack link.
- Acts as the slave of the link: captures each handshaked data word into a small FIFO and presents it to downstream logic over a valid/ready interface.
- Also counts words per burst, keeps a running modulo-256 checksum, and pulses burst_done once BURST_LEN words have been accepted.

Parameters:
- DATA_W, 8, link and output data width in bits.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- BURST_LEN, 4, words per burst before burst_done pulses; minimum 1.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  link request from master; data is stable while req=1.
- data  input  DATA_W  link data from master.
- ack  output  1  link acknowledge to master (registered).
- out_data  output  DATA_W  FIFO head word; valid only when out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream consumer accepts head word.
- burst_done  output  1  one-cycle pulse when the BURST_LEN-th word of a burst is written.
- checksum  output  8  modulo-256 sum of the words in the last completed burst; held until the next burst completes.
- fill  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: clk and rst are the only clock/reset; reset is asynchronous and active-high. While rst=1: ack=0, out_valid=0, out_data=0, burst_done=0, checksum=0, fill=0. The FSM goes to IDLE, FIFO pointers and the word counter clear, and the running sum clears.
- A reset asserted mid-handshake drops ack immediately. A partially accumulated burst is discarded.
- FSM states:
  - IDLE (ack=0): if req=1 and fill<DEPTH at the clock edge, write data into the FIFO, set ack<=1, and go to WAIT_REL. If req=1 and the FIFO is full, stay in IDLE with ack=0; this is backpressure, and data is not sampled.
  - WAIT_REL (ack=1): when req=0, set ack<=0 and go to IDLE. While req stays 1, hold ack=1. No second write occurs within one handshake.
- Timing:
  - Capture latency: ack rises on the edge after req is seen high with space available.
  - The written word appears on out_data/out_valid on the following edge; this is registered FIFO state, not a combinational bypass.
  - Minimum handshake is 2 cycles of ack high/low per word, so a new req can be accepted the cycle after ack falls.
- FIFO:
  - Pop occurs when out_valid and out_ready are both 1; the head advances.
  - Pop when empty is ignored.
  - Simultaneous push and pop leaves fill unchanged and updates both pointers.
  - Space is judged on the registered fill value, so a push is refused when fill=DEPTH even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
  - out_data comes from the registered head entry.
- Burst accounting:
  - Each write increments the word counter and adds data[7:0] (zero-extended if DATA_W<8) to the running sum, modulo 256.
  - On the write that makes the count reach BURST_LEN: burst_done=1 for exactly one cycle, checksum is loaded with running_sum+data (the value including the last word), and the counter and running sum clear to 0.
  - Burst accounting is independent of downstream popping.
- Invariants:
  - ack never rises while req=0.
  - fill never exceeds DEPTH.

Test Plan:
- Reset mid-handshake: assert rst while ack=1 -> ack=0, fill=0, out_valid=0 asynchronously, before the next clock edge. After release, the next handshake of 0x11 completes normally.
- Single word: send 0xA5 with out_ready=0 -> ack rises 1 cycle after req. One cycle after capture, out_valid=1, out_data=0xA5, fill=1. After req drops, ack drops the next cycle.
- Burst: send 0x01,0x02,0x03,0x04 with out_ready=1 -> burst_done pulses exactly once, on the 4th write. checksum=0x0A and is held. Outputs appear in order 01,02,03,04.
- Checksum wrap: send burst 0xFF,0xFF,0x01,0x03 -> checksum=0x02.
- Backpressure: send 5 words with out_ready=0 -> 4 words acked, fill=4. The 5th req stays unacked (ack=0). Pulse out_ready for 1 cycle -> 0x01 is popped, fill drops to 3, and the 5th word is acked on the next edge.
- Simultaneous push/pop: with fill=2, keep out_ready=1 while a word is captured -> fill stays 2, and order is preserved across pointer wrap after 8+ words.
